// File: rtl/scoreboard_regfile.sv
// ============================================================================
// scoreboard_regfile
// ----------------------------------------------------------------------------
// Register file with a rename scoreboard and hardware accumulators.
// Each entry holds a valid bit, a rename tag and a 32-bit value. Issue marks
// an entry pending under a tag. Commit wakes every pending entry carrying
// that tag and writes the committed data into the named entry.
//
// The top N_ACC entries are accumulators. Each one has an N_REQ-way
// round-robin arbiter, a LATENCY-deep adder pipeline and an occupancy
// counter. A new add is accepted once the counter is <= 1. When it equals 1,
// the add in flight leaves the pipeline in the same cycle and is forwarded
// as operand A. This allows back-to-back adds without losing an update.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   rd_idx/rd_valid/rd_tag/rd_data [N_READ]
//                            combinational read ports (no write bypass)
//   issue, issue_reg, issue_tag
//                            mark an entry pending under a tag
//   commit, commit_reg, commit_tag, commit_data
//                            wake entries on a tag, write data to commit_reg
//   acc_req_valid/acc_req_ready/acc_req_data [N_REQ][N_ACC]
//                            addend requests per accumulator
//   acc_all_ready            every accumulator can accept this cycle
//   acc_idle                 no add in flight and no request pending
// ============================================================================
module scoreboard_regfile #(
    parameter int REG_WIDTH = 5,
    parameter int ROB_WIDTH = 4,
    parameter int N_READ    = 2,
    parameter int N_ACC     = 3,
    parameter int N_REQ     = 4,
    parameter int LATENCY   = 6
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [REG_WIDTH-1:0] rd_idx        [N_READ],
    output logic                 rd_valid      [N_READ],
    output logic [ROB_WIDTH-1:0] rd_tag        [N_READ],
    output logic [31:0]          rd_data       [N_READ],

    input  logic                 issue,
    input  logic [REG_WIDTH-1:0] issue_reg,
    input  logic [ROB_WIDTH-1:0] issue_tag,

    input  logic                 commit,
    input  logic [REG_WIDTH-1:0] commit_reg,
    input  logic [ROB_WIDTH-1:0] commit_tag,
    input  logic [31:0]          commit_data,

    input  logic                 acc_req_valid [N_REQ][N_ACC],
    output logic                 acc_req_ready [N_REQ][N_ACC],
    input  logic [31:0]          acc_req_data  [N_REQ][N_ACC],

    output logic                 acc_all_ready,
    output logic                 acc_idle
);

    localparam int N_ENT    = 2 ** REG_WIDTH;
    localparam int ACC_BASE = N_ENT - N_ACC;
    localparam int CW       = $clog2(LATENCY) + 1;
    localparam int PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAT  = CW'(LATENCY);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 valid_q [N_ENT];
    logic                 valid_d [N_ENT];
    logic [ROB_WIDTH-1:0] tag_q   [N_ENT];
    logic [ROB_WIDTH-1:0] tag_d   [N_ENT];
    logic [31:0]          data_q  [N_ENT];
    logic [31:0]          data_d  [N_ENT];

    logic [CW-1:0]        cnt_q   [N_ACC];
    logic [CW-1:0]        cnt_d   [N_ACC];
    logic [PW-1:0]        ptr_q   [N_ACC];
    logic [PW-1:0]        ptr_d   [N_ACC];
    logic [31:0]          pipe_q  [N_ACC][LATENCY];
    logic [31:0]          pipe_d  [N_ACC][LATENCY];

    // ------------------------------------------------------------------
    // Per-accumulator datapath signals
    // ------------------------------------------------------------------
    logic                 grant_any [N_ACC];
    logic [PW-1:0]        grant_idx [N_ACC];
    logic                 dispatch  [N_ACC];
    logic                 result_wr [N_ACC];
    logic [31:0]          op_a      [N_ACC];
    logic [31:0]          sum       [N_ACC];

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < N_READ; p++) begin
            rd_valid[p] = valid_q[rd_idx[p]];
            rd_tag[p]   = tag_q[rd_idx[p]];
            rd_data[p]  = data_q[rd_idx[p]];
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration. The search starts at ptr_q and the first
    // valid requester wins.
    // ------------------------------------------------------------------
    always_comb begin : arb
        int            r;
        logic [PW-1:0] rr;
        r  = 0;
        rr = '0;
        for (int a = 0; a < N_ACC; a++) begin
            grant_any[a] = 1'b0;
            grant_idx[a] = '0;
            for (int k = 0; k < N_REQ; k++) begin
                r  = (int'(ptr_q[a]) + k) % N_REQ;
                rr = PW'(r);
                if (!grant_any[a] && acc_req_valid[rr][a]) begin
                    grant_any[a] = 1'b1;
                    grant_idx[a] = rr;
                end
            end
        end
    end

    // Result leaves the pipeline while cnt == 1. That value is also the
    // freshest accumulator value, so it is forwarded as operand A.
    always_comb begin
        for (int a = 0; a < N_ACC; a++) begin
            dispatch[a]  = grant_any[a] && (cnt_q[a] <= CNT_ONE) && !reset;
            result_wr[a] = (cnt_q[a] == CNT_ONE);
            op_a[a]      = result_wr[a] ? pipe_q[a][LATENCY-1]
                                        : data_q[ACC_BASE + a];
            sum[a]       = op_a[a] + acc_req_data[grant_idx[a]][a];
        end
    end

    always_comb begin
        for (int r = 0; r < N_REQ; r++) begin
            for (int a = 0; a < N_ACC; a++) begin
                acc_req_ready[r][a] = dispatch[a] && (grant_idx[a] == PW'(r));
            end
        end
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    always_comb begin
        acc_all_ready = 1'b1;
        acc_idle      = 1'b1;
        for (int a = 0; a < N_ACC; a++) begin
            if (cnt_q[a] > CNT_ONE) begin
                acc_all_ready = 1'b0;
            end
            if (cnt_q[a] != CNT_ZERO) begin
                acc_idle = 1'b0;
            end
            for (int r = 0; r < N_REQ; r++) begin
                if (acc_req_valid[r][a]) begin
                    acc_idle = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file next state.
    // Write order: commit first, then accumulator results overwrite data,
    // and finally issue overwrites valid/tag.
    // ------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;

        if (commit) begin
            for (int e = 0; e < N_ENT; e++) begin
                if (!valid_q[e] && (tag_q[e] == commit_tag)) begin
                    valid_d[e] = 1'b1;
                end
            end
            if (!valid_q[commit_reg]) begin
                data_d[commit_reg] = commit_data;
            end
        end

        for (int a = 0; a < N_ACC; a++) begin
            if (result_wr[a]) begin
                data_d[ACC_BASE + a] = pipe_q[a][LATENCY-1];
            end
        end

        if (issue) begin
            valid_d[issue_reg] = 1'b0;
            tag_d[issue_reg]   = issue_tag;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator next state
    // ------------------------------------------------------------------
    always_comb begin : acc_next
        int nxt;
        nxt = 0;
        for (int a = 0; a < N_ACC; a++) begin
            if (dispatch[a]) begin
                cnt_d[a] = CNT_LAT;
            end else if (cnt_q[a] != CNT_ZERO) begin
                cnt_d[a] = cnt_q[a] - CNT_ONE;
            end else begin
                cnt_d[a] = cnt_q[a];
            end

            nxt      = (int'(grant_idx[a]) + 1) % N_REQ;
            ptr_d[a] = dispatch[a] ? PW'(nxt) : ptr_q[a];

            // Stage contents only matter while cnt tracks them, so the
            // pipe shifts freely every cycle.
            pipe_d[a][0] = sum[a];
            for (int s = 1; s < LATENCY; s++) begin
                pipe_d[a][s] = pipe_q[a][s-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < N_ENT; e++) begin
                valid_q[e] <= 1'b1;
                tag_q[e]   <= '0;
                data_q[e]  <= '0;
            end
            for (int a = 0; a < N_ACC; a++) begin
                cnt_q[a] <= '0;
                ptr_q[a] <= '0;
                for (int s = 0; s < LATENCY; s++) begin
                    pipe_q[a][s] <= '0;
                end
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            pipe_q  <= pipe_d;
        end
    end

endmodule

// File: tb/tb_scoreboard_regfile.sv
module tb_scoreboard_regfile;

    localparam int RW   = 5;
    localparam int TW   = 4;
    localparam int NR   = 2;
    localparam int NA   = 3;
    localparam int NQ   = 4;
    localparam int L    = 6;
    localparam int NE   = 32;
    localparam int BASE = NE - NA;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] rd_idx   [NR];
    logic          rd_valid [NR];
    logic [TW-1:0] rd_tag   [NR];
    logic [31:0]   rd_data  [NR];
    logic          issue;
    logic [RW-1:0] issue_reg;
    logic [TW-1:0] issue_tag;
    logic          commit;
    logic [RW-1:0] commit_reg;
    logic [TW-1:0] commit_tag;
    logic [31:0]   commit_data;
    logic          acc_req_valid [NQ][NA];
    logic          acc_req_ready [NQ][NA];
    logic [31:0]   acc_req_data  [NQ][NA];
    logic          acc_all_ready;
    logic          acc_idle;

    always #5 clk = ~clk;

    scoreboard_regfile #(
        .REG_WIDTH(RW), .ROB_WIDTH(TW), .N_READ(NR),
        .N_ACC(NA), .N_REQ(NQ), .LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_data(rd_data),
        .issue(issue), .issue_reg(issue_reg), .issue_tag(issue_tag),
        .commit(commit), .commit_reg(commit_reg), .commit_tag(commit_tag),
        .commit_data(commit_data),
        .acc_req_valid(acc_req_valid), .acc_req_ready(acc_req_ready),
        .acc_req_data(acc_req_data),
        .acc_all_ready(acc_all_ready), .acc_idle(acc_idle)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected outputs for one cycle
    typedef struct packed {
        int            cyc;
        logic [1:0]    rv;
        logic [7:0]    rt;
        logic [63:0]   rd;
        logic [11:0]   rdy;
        logic          ar;
        logic          id;
    } exp_t;

    exp_t exp_q[$];

    // ------------------------------------------------------------------
    // Reference model. The accumulator is modelled as a pending result with
    // an absolute landing cycle. The model does not use a counter.
    // ------------------------------------------------------------------
    logic        mv [NE];
    logic [3:0]  mt [NE];
    logic [31:0] md [NE];
    bit          hp [NA];
    int          pc [NA];
    logic [31:0] pv [NA];
    int          ptr[NA];
    int          win[NA];
    int          cyc;

    task automatic model_reset();
        for (int e = 0; e < NE; e++) begin
            mv[e] = 1'b1; mt[e] = '0; md[e] = '0;
        end
        for (int a = 0; a < NA; a++) begin
            hp[a] = 0; pc[a] = 0; pv[a] = '0; ptr[a] = 0; win[a] = -1;
        end
    endtask

    function automatic int find_win(input int a);
        for (int k = 0; k < NQ; k++) begin
            if (acc_req_valid[(ptr[a] + k) % NQ][a]) return (ptr[a] + k) % NQ;
        end
        return -1;
    endfunction

    task automatic push_expect();
        exp_t e;
        bit   can;
        e = '0;
        e.cyc = cyc; e.ar = 1'b1; e.id = 1'b1;
        for (int p = 0; p < NR; p++) begin
            e.rv[p]          = mv[rd_idx[p]];
            e.rt[p*TW +: TW] = mt[rd_idx[p]];
            e.rd[p*32 +: 32] = md[rd_idx[p]];
        end
        for (int a = 0; a < NA; a++) begin
            can    = !hp[a] || (pc[a] == cyc);
            win[a] = (!reset && can) ? find_win(a) : -1;
            if (win[a] >= 0) e.rdy[win[a]*NA + a] = 1'b1;
            if (!can) e.ar = 1'b0;
            if (hp[a]) e.id = 1'b0;
            for (int r = 0; r < NQ; r++) if (acc_req_valid[r][a]) e.id = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    task automatic model_edge();
        logic        nv [NE];
        logic [3:0]  nt [NE];
        logic [31:0] nd [NE];
        logic [31:0] opa;
        bit          lands;
        if (reset) begin
            model_reset();
            return;
        end
        nv = mv; nt = mt; nd = md;
        if (commit) begin
            for (int e = 0; e < NE; e++)
                if (!mv[e] && mt[e] == commit_tag) nv[e] = 1'b1;
            if (!mv[commit_reg]) nd[commit_reg] = commit_data;
        end
        for (int a = 0; a < NA; a++) begin
            lands = hp[a] && (pc[a] == cyc);
            opa   = lands ? pv[a] : md[BASE + a];
            if (lands) begin
                nd[BASE + a] = pv[a];
                hp[a] = 0;
            end
            if (win[a] >= 0) begin
                pv[a]  = opa + acc_req_data[win[a]][a];
                hp[a]  = 1;
                pc[a]  = cyc + L;
                ptr[a] = (win[a] + 1) % NQ;
            end
        end
        if (issue) begin
            nv[issue_reg] = 1'b0;
            nt[issue_reg] = issue_tag;
        end
        mv = nv; mt = nt; md = nd;
    endtask

    task automatic cycle_go();
        push_expect();
        @(posedge clk);
        #1;
        model_edge();
        cyc++;
    endtask

    task automatic clear_inputs();
        reset = 1'b0; issue = 1'b0; commit = 1'b0;
        issue_reg = '0; issue_tag = '0;
        commit_reg = '0; commit_tag = '0; commit_data = '0;
        for (int r = 0; r < NQ; r++)
            for (int a = 0; a < NA; a++) begin
                acc_req_valid[r][a] = 1'b0;
                acc_req_data[r][a]  = '0;
            end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        cycle_go();
        reset = 1'b0;
    endtask

    // Hold requests on accumulator a until each one is granted, then let the
    // final result land.
    task automatic drain(input int a, input string name);
        int n;
        bit any;
        n = 0;
        do begin
            cycle_go();
            any = 0;
            for (int r = 0; r < NQ; r++) begin
                if (win[a] == r) acc_req_valid[r][a] = 1'b0;
                if (acc_req_valid[r][a]) any = 1;
            end
            n++;
        end while (any && n < 60);
        chk({name, "_grant_timeout"}, 64'(any), 64'(0));
        repeat (L + 1) cycle_go();
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares one expected record with the DUT outputs every
    // cycle.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t        e;
        logic [11:0] got_rdy;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got_rdy = '0;
            for (int r = 0; r < NQ; r++)
                for (int a = 0; a < NA; a++)
                    got_rdy[r*NA + a] = acc_req_ready[r][a];
            for (int p = 0; p < NR; p++) begin
                chk($sformatf("rd_valid[%0d] cyc%0d", p, e.cyc), 64'(rd_valid[p]), 64'(e.rv[p]));
                chk($sformatf("rd_tag[%0d] cyc%0d", p, e.cyc), 64'(rd_tag[p]), 64'(e.rt[p*TW +: TW]));
                chk($sformatf("rd_data[%0d] cyc%0d", p, e.cyc), 64'(rd_data[p]), 64'(e.rd[p*32 +: 32]));
            end
            chk($sformatf("acc_req_ready cyc%0d", e.cyc), 64'(got_rdy), 64'(e.rdy));
            chk($sformatf("acc_all_ready cyc%0d", e.cyc), 64'(acc_all_ready), 64'(e.ar));
            chk($sformatf("acc_idle cyc%0d", e.cyc), 64'(acc_idle), 64'(e.id));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        cyc = 0;
        clear_inputs();
        reset = 1'b1;
        for (int p = 0; p < NR; p++) rd_idx[p] = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;

        // Post-reset state
        rd_idx[0] = RW'(0); rd_idx[1] = RW'(31);
        #1;
        chk("reset_rd_valid", 64'(rd_valid[1]), 64'(1));
        chk("reset_rd_data", 64'(rd_data[1]), 64'(0));
        chk("reset_all_ready", 64'(acc_all_ready), 64'(1));
        chk("reset_idle", 64'(acc_idle), 64'(1));
        cycle_go();

        // Issue then commit
        issue = 1'b1; issue_reg = RW'(3); issue_tag = TW'(5); rd_idx[0] = RW'(3);
        cycle_go();
        issue = 1'b0;
        #1;
        chk("r3_pending_valid", 64'(rd_valid[0]), 64'(0));
        commit = 1'b1; commit_reg = RW'(3); commit_tag = TW'(5); commit_data = 32'hDEADBEEF;
        cycle_go();
        commit = 1'b0;
        #1;
        chk("r3_commit_valid", 64'(rd_valid[0]), 64'(1));
        chk("r3_commit_data", 64'(rd_data[0]), 64'h0DEADBEEF);

        // Same-cycle issue and commit on one entry
        issue = 1'b1; issue_reg = RW'(7); issue_tag = TW'(2);
        cycle_go();
        commit = 1'b1; commit_reg = RW'(7); commit_tag = TW'(2); commit_data = 32'hCAFE0007;
        rd_idx[0] = RW'(7);
        cycle_go();
        clear_inputs();
        #1;
        chk("r7_valid", 64'(rd_valid[0]), 64'(0));
        chk("r7_tag", 64'(rd_tag[0]), 64'(2));
        chk("r7_data", 64'(rd_data[0]), 64'hCAFE0007);

        // Three requesters on acc 0
        do_reset();
        for (int r = 0; r < 3; r++) begin
            acc_req_valid[r][0] = 1'b1;
            acc_req_data[r][0]  = 32'(r + 1);
        end
        drain(0, "acc0_rr");
        rd_idx[0] = RW'(BASE);
        #1;
        chk("acc0_sum", 64'(rd_data[0]), 64'(6));

        // Back-to-back adds on acc 1 with wrap
        do_reset();
        acc_req_valid[0][1] = 1'b1; acc_req_data[0][1] = 32'd10;
        acc_req_valid[1][1] = 1'b1; acc_req_data[1][1] = 32'hFFFFFFFF;
        drain(1, "acc1_bypass");
        rd_idx[0] = RW'(BASE + 1);
        #1;
        chk("acc1_wrap", 64'(rd_data[0]), 64'(9));

        // Reset while acc 2 is mid-flight
        do_reset();
        acc_req_valid[0][2] = 1'b1; acc_req_data[0][2] = 32'd7;
        cycle_go();
        acc_req_valid[0][2] = 1'b0;
        repeat (3) cycle_go();
        reset = 1'b1;
        cycle_go();
        reset = 1'b0;
        repeat (L + 2) cycle_go();
        rd_idx[0] = RW'(BASE + 2);
        #1;
        chk("acc2_flushed", 64'(rd_data[0]), 64'(0));
        chk("acc2_idle", 64'(acc_idle), 64'(1));

        // Commit to acc 0 in its result-write cycle
        issue = 1'b1; issue_reg = RW'(BASE); issue_tag = TW'(9);
        cycle_go();
        issue = 1'b0;
        acc_req_valid[0][0] = 1'b1; acc_req_data[0][0] = 32'd5;
        cycle_go();
        acc_req_valid[0][0] = 1'b0;
        n = 0;
        while (!(hp[0] && pc[0] == cyc) && n < 20) begin
            cycle_go();
            n++;
        end
        chk("acc0_land_timeout", 64'(n < 20), 64'(1));
        commit = 1'b1; commit_reg = RW'(BASE); commit_tag = TW'(9); commit_data = 32'h1234;
        cycle_go();
        commit = 1'b0;
        rd_idx[0] = RW'(BASE);
        #1;
        chk("acc0_result_kept", 64'(rd_data[0]), 64'(5));
        chk("acc0_commit_valid", 64'(rd_valid[0]), 64'(1));

        // Random traffic
        repeat (1500) begin
            reset      = ($urandom_range(0, 199) == 0);
            issue      = ($urandom_range(0, 2) == 0);
            issue_reg  = RW'($urandom);
            issue_tag  = TW'($urandom);
            commit     = ($urandom_range(0, 2) == 0);
            commit_reg = ($urandom_range(0, 3) == 0) ? RW'(BASE + $urandom_range(0, 2)) : RW'($urandom);
            commit_tag = TW'($urandom);
            commit_data = $urandom;
            for (int p = 0; p < NR; p++)
                rd_idx[p] = $urandom_range(0, 1) ? RW'(BASE + $urandom_range(0, 2)) : RW'($urandom);
            for (int r = 0; r < NQ; r++)
                for (int a = 0; a < NA; a++) begin
                    acc_req_valid[r][a] = ($urandom_range(0, 2) == 0);
                    acc_req_data[r][a]  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
                end
            cycle_go();
        end

        clear_inputs();
        repeat (L + 2) cycle_go();
        @(negedge clk);
        #1;
        chk("exp_queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
